// File: rtl/sp_mem_resp_buffer_pkg.sv
// Shared definitions for the scratchpad response buffer and its scratchpad
// wrappers: default widths, request direction encoding and a pointer-width
// helper used by the response FIFO.
package sp_mem_resp_buffer_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 1024;
    localparam int TAG_W_DEF  = 10;
    localparam int DEPTH_DEF  = 4;

    // io_in_bits_rw encoding
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Width of a pointer that indexes 0..depth-1 (at least one bit).
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sp_mem_resp_buffer_if.sv
// Bus bundle between an engine port, the response buffer and the scratchpad.
//   slave  : view taken by sp_mem_resp_buffer (accepts requests, drives the
//            scratchpad request, presents responses)
//   master : view taken by the surroundings (engine + scratchpad model)
// Signal groups:
//   io_in_*   engine request (valid/ready, address, rw, write data, tag)
//   mem_in_*  scratchpad request (valid/ready, pass-through request bits)
//   mem_out_* scratchpad read data, valid one cycle after a read is issued
//   io_out_*  tagged read response (valid/ready, read data, tag)
interface sp_mem_resp_buffer_if
    import sp_mem_resp_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic              io_in_valid;
    logic              io_in_ready;
    logic [ADDR_W-1:0] io_in_bits_address;
    logic              io_in_bits_rw;
    logic [DATA_W-1:0] io_in_bits_wData;
    logic [TAG_W-1:0]  io_in_tag;

    logic              mem_in_valid;
    logic              mem_in_ready;
    logic [ADDR_W-1:0] mem_in_bits_address;
    logic              mem_in_bits_rw;
    logic [DATA_W-1:0] mem_in_bits_wData;
    logic [DATA_W-1:0] mem_out_bits_rData;

    logic              io_out_valid;
    logic              io_out_ready;
    logic [DATA_W-1:0] io_out_bits_rData;
    logic [TAG_W-1:0]  io_out_tag;

    modport slave (
        input  io_in_valid, io_in_bits_address, io_in_bits_rw, io_in_bits_wData, io_in_tag,
        output io_in_ready,
        output mem_in_valid, mem_in_bits_address, mem_in_bits_rw, mem_in_bits_wData,
        input  mem_in_ready, mem_out_bits_rData,
        output io_out_valid, io_out_bits_rData, io_out_tag,
        input  io_out_ready
    );

    modport master (
        output io_in_valid, io_in_bits_address, io_in_bits_rw, io_in_bits_wData, io_in_tag,
        input  io_in_ready,
        input  mem_in_valid, mem_in_bits_address, mem_in_bits_rw, mem_in_bits_wData,
        output mem_in_ready, mem_out_bits_rData,
        input  io_out_valid, io_out_bits_rData, io_out_tag,
        output io_out_ready
    );

endinterface

// File: rtl/sp_mem_resp_buffer_resp_fifo.sv
// sp_resp_fifo: circular response FIFO, DEPTH entries of WIDTH bits.
// The head entry is read straight out of the storage registers, so there is
// no bypass: a push into an empty FIFO shows up on headValid one cycle later.
// Ports:
//   clk, reset        clock, synchronous active-high reset (pointers/count only)
//   push, pushData    write one entry at the tail
//   pop               remove the head entry (ignored when empty)
//   headValid         FIFO not empty
//   headData          oldest entry
//   count             number of stored entries, 0..DEPTH
module sp_resp_fifo
    import sp_mem_resp_buffer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic                       headValid,
    output logic [WIDTH-1:0]           headData,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = ptrWidth(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] cnt;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only taken when the head leaves in the
    // same cycle; the upstream credit check keeps that from ever being needed.
    always_comb begin
        doPop  = pop && (cnt != '0);
        doPush = push && ((cnt != CNT_W'(DEPTH)) || doPop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            cnt <= cnt + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) store[wrPtr] <= pushData;
    end

    assign headValid = (cnt != '0);
    assign headData  = store[rdPtr];
    assign count     = cnt;

endmodule

// File: rtl/sp_mem_resp_buffer.sv
// sp_mem_resp_buffer: flow-controlled front end for a 1-cycle-latency
// scratchpad whose read data is always-valid and untagged. Requests are
// accepted with valid/ready and forwarded to the scratchpad; one cycle after
// a read is issued its data is captured together with the request tag into a
// response FIFO that the consumer drains with valid/ready.
// Ports:
//   clk    single clock
//   reset  synchronous, active-high; drops an in-flight read, flushes the FIFO
//   bus    sp_mem_resp_buffer_if.slave (engine request, scratchpad request and
//          read data, tagged response)
module sp_mem_resp_buffer
    import sp_mem_resp_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    sp_mem_resp_buffer_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2) begin : gDepthCheck
        $error("sp_mem_resp_buffer: DEPTH must be at least 2");
    end

    logic [CNT_W-1:0]        fifoCount;
    logic [CNT_W:0]          inFlight;
    logic                    inReady;
    logic                    accept;
    logic                    acceptRead;
    logic [ADDR_W-1:0]       reqAddr;
    logic                    pendVld_p1;
    logic [TAG_W-1:0]        pendTag_p1;
    logic                    fifoPop;
    logic [DATA_W+TAG_W-1:0] fifoHead;

    // Every accepted read owns a FIFO slot from acceptance until it is popped:
    // it is either pending (data arrives next cycle) or already stored. Only
    // registered state is used, so io_out_ready never reaches io_in_ready.
    always_comb begin
        inFlight   = {1'b0, fifoCount} + (CNT_W + 1)'(pendVld_p1);
        inReady    = !reset && bus.mem_in_ready && (inFlight < (CNT_W + 1)'(DEPTH));
        accept     = bus.io_in_valid && inReady;
        acceptRead = accept && (bus.io_in_bits_rw == RW_READ);
    end

    assign reqAddr                 = bus.io_in_bits_address;
    assign bus.io_in_ready         = inReady;
    assign bus.mem_in_valid        = accept;
    assign bus.mem_in_bits_address = reqAddr;
    assign bus.mem_in_bits_rw      = bus.io_in_bits_rw;
    assign bus.mem_in_bits_wData   = bus.io_in_bits_wData;

    // ---- stage p1: read issued last cycle, its data is on mem_out_bits_rData ----
    always_ff @(posedge clk) begin
        if (reset) pendVld_p1 <= 1'b0;
        else       pendVld_p1 <= acceptRead;
    end

    always_ff @(posedge clk) begin
        if (acceptRead) pendTag_p1 <= bus.io_in_tag;
    end

    // ---- stage p2: captured response waits in the FIFO ----
    assign fifoPop = bus.io_out_valid && bus.io_out_ready;

    sp_resp_fifo #(
        .WIDTH (DATA_W + TAG_W),
        .DEPTH (DEPTH)
    ) uRespFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pendVld_p1),
        .pushData  ({bus.mem_out_bits_rData, pendTag_p1}),
        .pop       (fifoPop),
        .headValid (bus.io_out_valid),
        .headData  (fifoHead),
        .count     (fifoCount)
    );

    assign bus.io_out_bits_rData = fifoHead[DATA_W+TAG_W-1:TAG_W];
    assign bus.io_out_tag        = fifoHead[TAG_W-1:0];

endmodule
